mem_slot_arbiter: RTL

- Master-clock (14.318 MHz) bus sequencer that time-shares the single-port system RAM between three requesters: video scanner, 6502 CPU, DMA (disk/expansion).
- Divides the master clock into CPU cycles and issues one video access plus one CPU-or-DMA access per cycle.
- Produces the one-clock enable that steps the cpu65xx core.
- Sits between cpu65xx, the video fetch logic and the ram instance in the top level.

---
 rtl/mem_slot_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mem_slot_arbiter.sv
// Master-clock bus sequencer: shares one synchronous single-port RAM between
// the video scanner (phase 0 of every CPU cycle) and a CPU-or-DMA slot
// (phase DIV-3), and produces the CPU step enable.
//
// All outputs are flops loaded from next-phase decode, so a strobe shown as
// "at phase p" is high during the clock in which phase_q == p.  Read data is
// captured on the edge that ends the phase after the RAM select. The video
// fetch of cycle 0 straight out of reset is not issued, because ram_cs
// resets low.
module mem_slot_arbiter #(
  parameter int DIV         = 14,
  parameter int STRETCH     = 2,
  parameter int LINE_CYCLES = 65,
  parameter int DMA_BURST   = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ce,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic [DATA_WIDTH-1:0] vid_rdata,
  output logic                  vid_valid,
  input  logic                  dma_req,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic                  dma_we,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_done,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int PW = $clog2(DIV + STRETCH + 1);
  localparam int CW = $clog2(LINE_CYCLES + 1);
  localparam int BW = $clog2(DMA_BURST + 1);

  localparam logic [PW-1:0] PH_VID       = '0;
  localparam logic [PW-1:0] PH_VID_RD    = PW'(1);
  localparam logic [PW-1:0] PH_VID_VALID = PW'(2);
  localparam logic [PW-1:0] PH_ARB       = PW'(7);
  localparam logic [PW-1:0] PH_GNT       = PW'(8);
  localparam logic [PW-1:0] PH_SLOT      = PW'(DIV - 3);
  localparam logic [PW-1:0] PH_SLOT_RD   = PW'(DIV - 2);
  localparam logic [PW-1:0] PH_LAST_S    = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_LAST_L    = PW'(DIV + STRETCH - 1);
  localparam logic [CW-1:0] CYC_LAST     = CW'(LINE_CYCLES - 1);
  localparam logic [BW-1:0] BURST_MAX    = BW'(DMA_BURST);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  logic [PW-1:0]         phase_q, phase_d, phase_last, next_last;
  logic [CW-1:0]         cycle_q, cycle_d;
  owner_e                owner_q, owner_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic                  acc_we_q, acc_we_d;

  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;
  logic [DATA_WIDTH-1:0] vid_rdata_q, vid_rdata_d;
  logic                  cpu_ce_q, cpu_ce_d;
  logic                  vid_valid_q, vid_valid_d;
  logic                  dma_gnt_q, dma_gnt_d;
  logic                  dma_done_q, dma_done_d;
  logic                  ram_cs_q, ram_cs_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;

  // Next-state decode: phase/cycle timing, arbitration, RAM slots, strobes.
  always_comb begin
    phase_last = (cycle_q == CYC_LAST) ? PH_LAST_L : PH_LAST_S;
    phase_d    = phase_q + 1'b1;
    cycle_d    = cycle_q;
    if (phase_q == phase_last) begin
      phase_d = '0;
      cycle_d = (cycle_q == CYC_LAST) ? '0 : cycle_q + 1'b1;
    end
    next_last = (cycle_d == CYC_LAST) ? PH_LAST_L : PH_LAST_S;

    // Owner for the rest of the cycle is decided on the edge leaving phase 7.
    owner_d = owner_q;
    burst_d = burst_q;
    if (phase_q == PH_ARB) begin
      if (dma_req && (burst_q < BURST_MAX)) begin
        owner_d = OWN_DMA;
        burst_d = burst_q + 1'b1;
      end else begin
        owner_d = OWN_CPU;
        burst_d = '0;
      end
    end

    // Address/data hold between accesses so the bus only moves when selected.
    ram_cs_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    acc_we_d    = acc_we_q;
    if (phase_d == PH_VID) begin
      ram_cs_d   = 1'b1;
      ram_addr_d = vid_addr;
    end else if (phase_d == PH_SLOT) begin
      ram_cs_d = 1'b1;
      if (owner_d == OWN_DMA) begin
        ram_we_d    = dma_we;
        ram_addr_d  = dma_addr;
        ram_wdata_d = dma_wdata;
      end else begin
        ram_we_d    = cpu_we;
        ram_addr_d  = cpu_addr;
        ram_wdata_d = cpu_wdata;
      end
      acc_we_d = ram_we_d;
    end

    vid_rdata_d = vid_rdata_q;
    if (phase_q == PH_VID_RD) vid_rdata_d = ram_rdata;

    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    if ((phase_q == PH_SLOT_RD) && !acc_we_q) begin
      if (owner_q == OWN_DMA) dma_rdata_d = ram_rdata;
      else                    cpu_rdata_d = ram_rdata;
    end

    vid_valid_d = (phase_d == PH_VID_VALID);
    dma_gnt_d   = (owner_d == OWN_DMA) && (phase_d >= PH_GNT);
    dma_done_d  = (owner_d == OWN_DMA) && (phase_d == next_last);
    cpu_ce_d    = (owner_d == OWN_CPU) && (phase_d == next_last);
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= '0;
      cycle_q     <= '0;
      owner_q     <= OWN_CPU;
      burst_q     <= '0;
      acc_we_q    <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      vid_rdata_q <= '0;
      cpu_ce_q    <= 1'b0;
      vid_valid_q <= 1'b0;
      dma_gnt_q   <= 1'b0;
      dma_done_q  <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      phase_q     <= phase_d;
      cycle_q     <= cycle_d;
      owner_q     <= owner_d;
      burst_q     <= burst_d;
      acc_we_q    <= acc_we_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      cpu_ce_q    <= cpu_ce_d;
      vid_valid_q <= vid_valid_d;
      dma_gnt_q   <= dma_gnt_d;
      dma_done_q  <= dma_done_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ce    = cpu_ce_q;
  assign vid_rdata = vid_rdata_q;
  assign vid_valid = vid_valid_q;
  assign dma_gnt   = dma_gnt_q;
  assign dma_done  = dma_done_q;
  assign dma_rdata = dma_rdata_q;
  assign ram_cs    = ram_cs_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule
